// File: rtl/imem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : imem_pkg
// Purpose  : Shared constants and the loader state encoding used by the
//            instruction-memory write path (loader, memory, bench).
// Contents : IM_SIZE_DEFAULT  - default instruction memory size in bytes
//            BYTES_PER_WORD   - bytes per instruction word
//            loader_state_e   - 3-bit loader FSM encoding
// Revision : 1.0 - initial release
// ============================================================================
package imem_pkg;

  localparam int IM_SIZE_DEFAULT = 1024;
  localparam int BYTES_PER_WORD  = 4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ACCEPT = 3'd1,
    WRITE  = 3'd2,
    DONE   = 3'd3,
    ERROR  = 3'd4
  } loader_state_e;

endpackage
`default_nettype wire

// File: rtl/imem_loader_if.sv
`default_nettype none
// ============================================================================
// Module   : imem_loader_if
// Purpose  : Groups the word stream (host -> loader) and the byte write
//            port (loader -> instruction memory).
// Signals  : word_valid/word_data/word_last/word_ready - word stream
//            mem_we/mem_addr/mem_wdata                 - byte write port
// Modports : master - host side (drives the stream, observes the writes)
//            slave  - loader side
// Revision : 1.0 - initial release
// ============================================================================
interface imem_loader_if;

  logic        word_valid;
  logic [31:0] word_data;
  logic        word_last;
  logic        word_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [7:0]  mem_wdata;

  modport master (
    output word_valid, word_data, word_last,
    input  word_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  word_valid, word_data, word_last,
    output word_ready, mem_we, mem_addr, mem_wdata
  );

endinterface
`default_nettype wire

// File: rtl/word_byte_serializer.sv
`default_nettype none
// ============================================================================
// Module   : word_byte_serializer
// Purpose  : Holds one 32-bit word and presents it one byte at a time,
//            most significant byte first.
// Ports    : clock, reset  - clock / async active-high reset
//            load, word    - capture a new word and restart at byte 0
//            advance       - step to the next byte
//            byte_out      - currently selected byte
//            idx           - current byte index (0 = MSB)
//            last_byte     - idx is on the final byte
// Revision : 1.0 - initial release
// ============================================================================
module word_byte_serializer (
  input  wire logic        clock,
  input  wire logic        reset,
  input  wire logic        load,
  input  wire logic        advance,
  input  wire logic [31:0] word,
  output logic      [7:0]  byte_out,
  output logic      [1:0]  idx,
  output logic             last_byte
);

  logic [31:0] word_q, word_d;
  logic [1:0]  idx_q,  idx_d;

  always_comb begin
    word_d = word_q;
    idx_d  = idx_q;
    if (load) begin
      word_d = word;
      idx_d  = 2'd0;
    end else if (advance) begin
      idx_d = idx_q + 2'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      word_q <= 32'd0;
      idx_q  <= 2'd0;
    end else begin
      word_q <= word_d;
      idx_q  <= idx_d;
    end
  end

  always_comb begin
    byte_out = word_q[31:24];
    case (idx_q)
      2'd0:    byte_out = word_q[31:24];
      2'd1:    byte_out = word_q[23:16];
      2'd2:    byte_out = word_q[15:8];
      default: byte_out = word_q[7:0];
    endcase
  end

  assign idx       = idx_q;
  assign last_byte = (idx_q == 2'd3);

endmodule
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module   : imem_loader
// Purpose  : Accepts 32-bit instruction words on a valid/ready stream and
//            writes them, MSB first, into the instruction memory byte port
//            starting at BASE_ADDR. One accept cycle plus four write cycles
//            per word.
// Ports    : clock, reset     - clock / async active-high reset
//            start            - begins a session (ignored while busy)
//            bus (slave)      - word stream in, byte write port out
//            busy             - in ACCEPT or WRITE
//            done             - session finished normally (sticky)
//            overflow         - word rejected past IM_SIZE (sticky)
//            words_loaded     - words fully written this session
//            checksum         - mod-2^32 sum of accepted words
// Options  : IMEM_LOADER_CHECKSUM_EN - build the checksum adder; when not
//            defined the checksum port is tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module imem_loader
  import imem_pkg::*;
#(
  parameter int IM_SIZE   = IM_SIZE_DEFAULT,
  parameter int BASE_ADDR = 0
) (
  input  wire logic        clock,
  input  wire logic        reset,
  input  wire logic        start,
  imem_loader_if.slave     bus,
  output logic             busy,
  output logic             done,
  output logic             overflow,
  output logic      [31:0] words_loaded,
  output logic      [31:0] checksum
);

  localparam logic [32:0] IM_LIMIT = 33'(IM_SIZE);

  loader_state_e state_q, state_d;
  logic [31:0]   addr_q, addr_d;
  logic          last_q, last_d;
  logic          done_q, done_d;
  logic          overflow_q, overflow_d;
  logic [31:0]   words_q, words_d;
  logic [31:0]   hold_addr_q, hold_addr_d;
  logic [7:0]    hold_wdata_q, hold_wdata_d;

  logic          ser_load, ser_advance, ser_last;
  logic [7:0]    ser_byte;
  logic [1:0]    ser_idx;
  logic          word_ready_c, mem_we_c, busy_c;
  logic          word_fits;

  // 33-bit compare so an address near 2^32 cannot wrap past the check.
  assign word_fits = ({1'b0, addr_q} + 33'(BYTES_PER_WORD)) <= IM_LIMIT;

  word_byte_serializer u_ser (
    .clock     (clock),
    .reset     (reset),
    .load      (ser_load),
    .advance   (ser_advance),
    .word      (bus.word_data),
    .byte_out  (ser_byte),
    .idx       (ser_idx),
    .last_byte (ser_last)
  );

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    last_d       = last_q;
    done_d       = done_q;
    overflow_d   = overflow_q;
    words_d      = words_q;
    hold_addr_d  = hold_addr_q;
    hold_wdata_d = hold_wdata_q;
    ser_load     = 1'b0;
    ser_advance  = 1'b0;
    word_ready_c = 1'b0;
    mem_we_c     = 1'b0;
    busy_c       = 1'b0;

    case (state_q)
      IDLE, DONE, ERROR: begin
        if (start) begin
          addr_d     = 32'(BASE_ADDR);
          done_d     = 1'b0;
          overflow_d = 1'b0;
          words_d    = 32'd0;
          state_d    = ACCEPT;
        end
      end
      ACCEPT: begin
        word_ready_c = 1'b1;
        busy_c       = 1'b1;
        if (bus.word_valid) begin
          if (word_fits) begin
            ser_load = 1'b1;
            last_d   = bus.word_last;
            state_d  = WRITE;
          end else begin
            overflow_d = 1'b1;
            state_d    = ERROR;
          end
        end
      end
      WRITE: begin
        busy_c       = 1'b1;
        mem_we_c     = 1'b1;
        ser_advance  = 1'b1;
        addr_d       = addr_q + 32'd1;
        // Remember the last write so the port holds it once mem_we drops.
        hold_addr_d  = addr_q;
        hold_wdata_d = ser_byte;
        if (ser_last) begin
          words_d = words_q + 32'd1;
          if (last_q) begin
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            state_d = ACCEPT;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      addr_q       <= 32'd0;
      last_q       <= 1'b0;
      done_q       <= 1'b0;
      overflow_q   <= 1'b0;
      words_q      <= 32'd0;
      hold_addr_q  <= 32'd0;
      hold_wdata_q <= 8'd0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      last_q       <= last_d;
      done_q       <= done_d;
      overflow_q   <= overflow_d;
      words_q      <= words_d;
      hold_addr_q  <= hold_addr_d;
      hold_wdata_q <= hold_wdata_d;
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0] checksum_q, checksum_d;
  logic        start_take, word_take;

  assign start_take = start &&
                      ((state_q == IDLE) || (state_q == DONE) || (state_q == ERROR));
  assign word_take  = (state_q == ACCEPT) && bus.word_valid && word_fits;

  always_comb begin
    checksum_d = checksum_q;
    if (start_take) begin
      checksum_d = 32'd0;
    end else if (word_take) begin
      checksum_d = checksum_q + bus.word_data;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      checksum_q <= 32'd0;
    end else begin
      checksum_q <= checksum_d;
    end
  end

  assign checksum = checksum_q;
`else
  assign checksum = 32'd0;
`endif

  assign bus.word_ready = word_ready_c;
  assign bus.mem_we     = mem_we_c;
  assign bus.mem_addr   = mem_we_c ? addr_q : hold_addr_q;
  assign bus.mem_wdata  = mem_we_c ? ser_byte : hold_wdata_q;
  assign busy           = busy_c;
  assign done           = done_q;
  assign overflow       = overflow_q;
  assign words_loaded   = words_q;

  // Byte index is implied by ser_last; the full index is kept for debug.
  logic unused_idx;
  assign unused_idx = ^ser_idx;

endmodule
`default_nettype wire

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Write-side companion to the byte-addressed instruction memory. It accepts 32-bit instruction words over a valid/ready stream and writes them into the memory's byte write port, one byte per cycle, most significant byte first. Byte addresses start at BASE_ADDR and increase by 1, so a word fetched at PC reads back as {M[PC],M[PC+1],M[PC+2],M[PC+3]}. It sits between the boot/test host and instruction memory, and replaces file preloading for in-system programming.

Parameters:
IM_SIZE, 1024, instruction memory size in bytes; the highest writable byte address is IM_SIZE-1.
BASE_ADDR, 0, byte address of the first word; must be a multiple of 4.

Ports:
clock  input  1  single system clock, rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  one-cycle pulse that begins a load session; ignored while busy
word_valid  input  1  host has a word on word_data
word_data  input  32  instruction word
word_last  input  1  qualifies word_data as the final word of the session
word_ready  output  1  loader accepts a word this cycle
mem_we  output  1  byte write strobe to instruction memory
mem_addr  output  32  byte address of the write
mem_wdata  output  8  byte to write
busy  output  1  session in progress (ACCEPT or WRITE state)
done  output  1  session completed normally; sticky until the next start
overflow  output  1  word rejected because it would exceed IM_SIZE; sticky until the next start
words_loaded  output  32  number of words fully written in the current session
checksum  output  32  see Optional Feature

Behaviour:
- Reset (asynchronous, active-high) drives every output to 0: word_ready, mem_we, mem_addr, mem_wdata, busy, done, overflow, words_loaded, checksum. State returns to IDLE. A write sequence interrupted by reset is abandoned; partially written bytes stay in memory.
- FSM states: IDLE, ACCEPT, WRITE, DONE, ERROR.
- IDLE, DONE and ERROR: a start pulse sets addr=BASE_ADDR, clears done, overflow and words_loaded, and moves to ACCEPT. All other inputs are ignored in these states.
- ACCEPT: word_ready=1 and busy=1. A handshake (word_valid and word_ready) captures word_data and word_last.
  - If addr+4 > IM_SIZE: go to ERROR, set overflow=1, write nothing.
  - Otherwise: go to WRITE with byte index 0.
- start is ignored in ACCEPT and WRITE.
- WRITE: 4 consecutive cycles. Each cycle drives mem_we=1, mem_addr=addr and mem_wdata=word[31-8*idx -: 8], then addr increments by 1 and idx increments by 1. word_ready=0 throughout.
  - At the end of idx 3, words_loaded increments.
  - If the captured word_last=1, go to DONE and set done=1; otherwise return to ACCEPT.
- Throughput: 5 cycles per word (1 accept cycle plus 4 write cycles). The first mem_we occurs in the cycle after the handshake.
- mem_addr is 32 bits wide; the bounds check is done at 33-bit width so no wrap-around is possible. A session with exactly IM_SIZE/4 words completes with done=1 and overflow=0.
- mem_we is 0 in every state other than WRITE. mem_addr and mem_wdata hold their last value when mem_we=0.

Optional Feature:
IMEM_LOADER_CHECKSUM_EN
- Defined: checksum is the modulo-2^32 sum of all words accepted in the session. It is cleared on start and updated on each successful handshake; words rejected by overflow are not included.
- Undefined: the checksum port still exists but is tied to 0, and no adder is built.

Decomposition:
- Shared package imem_pkg holds:
  - IM_SIZE_DEFAULT = 1024
  - BYTES_PER_WORD = 4
  - the loader state encoding typedef/constants (IDLE=0, ACCEPT=1, WRITE=2, DONE=3, ERROR=4, 3 bits)
  - these are reused by instruction memory and by the bench.
- One sub-module is natural: word_byte_serializer. It takes a 32-bit word plus a load strobe and emits 4 MSB-first bytes with an index counter and a last_byte flag. The FSM, address counter and bounds check stay in imem_loader.

Test Plan:
- Single word 0x8C080004 with word_last=1 after start -> mem_we high for 4 cycles; addr 0..3 receive 8C,08,00,04; done=1; words_loaded=1; readback at PC=0 gives 0x8C080004.
- 3 words, word_valid toggled every other cycle -> word_ready only in ACCEPT; bytes land at addresses 0..11 MSB first; done only after the third word; words_loaded=3.
- IM_SIZE=16: 4 words fill the memory (done=1, overflow=0); a fifth word in a new session after 4 prior words -> overflow=1, no mem_we, state ERROR.
- start pulsed during WRITE -> ignored, sequence finishes unchanged. Reset asserted mid-WRITE (idx 2) -> all outputs 0 immediately, IDLE; a new start resumes at BASE_ADDR.
- With IMEM_LOADER_CHECKSUM_EN defined: words 0xFFFFFFFF and 0x00000002 -> checksum=0x00000001. Without the macro: checksum stays 0.
